// File: rtl/cond_flag_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit_if
// Description : Bus bundle between the pipeline/ALU side (master) and the
//               condition-flag unit (slave). It carries the ALU flag results
//               and update mask, the stall/call/return controls, and the
//               registered, bypassed and stack-status views.
//               Optional macro COND_FLAG_OVF_EN adds the overflow flag
//               (alu_ovf, ovf, ovf_byp) and widens upd_mask to 4 bits.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_flag_unit_if #(
    parameter int PTR_W = 2
);
`ifdef COND_FLAG_OVF_EN
    localparam int C_FLAG_W = 4;
`else
    localparam int C_FLAG_W = 3;
`endif

    // Master -> slave
    logic                alu_valid;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_sign;
`ifdef COND_FLAG_OVF_EN
    logic                alu_ovf;
`endif
    logic [C_FLAG_W-1:0] upd_mask;     // [0]=carry [1]=zero [2]=sign [3]=ovf
    logic                stall;
    logic                push;
    logic                pop;
    logic                err_clr;

    // Slave -> master
    logic                carry;
    logic                zero;
    logic                sign;
    logic                carry_byp;
    logic                zero_byp;
    logic                sign_byp;
`ifdef COND_FLAG_OVF_EN
    logic                ovf;
    logic                ovf_byp;
`endif
    logic [PTR_W:0]      stk_depth;
    logic                stk_full;
    logic                stk_empty;
    logic                stk_err;

    modport master (
        output alu_valid, alu_carry, alu_zero, alu_sign,
`ifdef COND_FLAG_OVF_EN
        output alu_ovf,
        input  ovf, ovf_byp,
`endif
        output upd_mask, stall, push, pop, err_clr,
        input  carry, zero, sign, carry_byp, zero_byp, sign_byp,
        input  stk_depth, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  alu_valid, alu_carry, alu_zero, alu_sign,
`ifdef COND_FLAG_OVF_EN
        input  alu_ovf,
        output ovf, ovf_byp,
`endif
        input  upd_mask, stall, push, pop, err_clr,
        output carry, zero, sign, carry_byp, zero_byp, sign_byp,
        output stk_depth, stk_full, stk_empty, stk_err
    );
endinterface
`default_nettype wire

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Architectural carry/zero/sign flag holder feeding the branch
//               unit. Captures masked ALU flag results, exposes a zero-latency
//               bypass of the next-state flags, and keeps a small LIFO of
//               saved flags for call/return with sticky error reporting.
//               Optional macro COND_FLAG_OVF_EN adds an overflow flag that
//               follows the same update/push/pop/reset rules.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - cond_flag_unit_if.slave (ALU results, update mask,
//                      stall/push/pop/err_clr in; registered flags, bypass
//                      flags, stack depth/full/empty/err out)
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int STK_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cond_flag_unit_if.slave   bus
);
`ifdef COND_FLAG_OVF_EN
    localparam int C_FLAG_W = 4;
`else
    localparam int C_FLAG_W = 3;
`endif
    localparam logic [PTR_W:0]   C_FULL_DEPTH = (PTR_W+1)'(STK_DEPTH);
    localparam logic [PTR_W:0]   C_ONE_DEPTH  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_ONE_PTR    = PTR_W'(1);

    // Flag vector layout: [0]=carry [1]=zero [2]=sign [3]=ovf (optional)
    logic [C_FLAG_W-1:0] r_flags;
    logic [C_FLAG_W-1:0] r_stk [STK_DEPTH];
    logic [PTR_W:0]      r_depth;
    logic                r_err;

    logic [C_FLAG_W-1:0] w_alu;
    logic [C_FLAG_W-1:0] w_next;
    logic [C_FLAG_W-1:0] w_stk_rd;
    logic [PTR_W-1:0]    w_rd_idx;
    logic                w_full;
    logic                w_empty;
    logic                w_act;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_err_ev;

`ifdef COND_FLAG_OVF_EN
    assign w_alu = {bus.alu_ovf, bus.alu_sign, bus.alu_zero, bus.alu_carry};
`else
    assign w_alu = {bus.alu_sign, bus.alu_zero, bus.alu_carry};
`endif

    assign w_full  = (r_depth == C_FULL_DEPTH);
    assign w_empty = (r_depth == '0);
    assign w_act   = ~bus.stall;

    // Push and pop only take effect alone; together they cancel and flag an
    // error. Overflowing push and underflowing pop are dropped with an error.
    assign w_do_push = w_act & bus.push & ~bus.pop & ~w_full;
    assign w_do_pop  = w_act & bus.pop & ~bus.push & ~w_empty;
    assign w_err_ev  = w_act & ((bus.push & bus.pop)
                              | (bus.push & ~bus.pop & w_full)
                              | (bus.pop & ~bus.push & w_empty));

    // Top-of-stack index. When full the low PTR_W bits are zero and the
    // subtraction wraps to STK_DEPTH-1, which is the correct entry.
    assign w_rd_idx = r_depth[PTR_W-1:0] - C_ONE_PTR;
    assign w_stk_rd = r_stk[w_rd_idx];

    // Next-state flags; also drive the bypass outputs. A successful pop
    // restores saved flags and discards any same-cycle ALU update.
    always_comb begin
        w_next = r_flags;
        if (w_do_pop) begin
            w_next = w_stk_rd;
        end else if (w_act && bus.alu_valid) begin
            w_next = (r_flags & ~bus.upd_mask) | (w_alu & bus.upd_mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_flags <= w_next;
            if (w_do_push) begin
                r_depth <= r_depth + C_ONE_DEPTH;
            end else if (w_do_pop) begin
                r_depth <= r_depth - C_ONE_DEPTH;
            end
            // New error wins over clear; clear still works while stalled.
            r_err <= w_err_ev | (r_err & ~bus.err_clr);
        end
    end

    // Stack storage holds no reset value; only entries below r_depth are
    // ever read. Push saves the pre-update registered flags.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_stk[r_depth[PTR_W-1:0]] <= r_flags;
        end
    end

    assign bus.carry     = r_flags[0];
    assign bus.zero      = r_flags[1];
    assign bus.sign      = r_flags[2];
    assign bus.carry_byp = w_next[0];
    assign bus.zero_byp  = w_next[1];
    assign bus.sign_byp  = w_next[2];
`ifdef COND_FLAG_OVF_EN
    assign bus.ovf       = r_flags[3];
    assign bus.ovf_byp   = w_next[3];
`endif
    assign bus.stk_depth = r_depth;
    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.stk_err   = r_err;

endmodule
`default_nettype wire
